// File: rtl/mini_alu_core.sv
// mini_alu_core: two-stage (fetch/execute) mini ALU with register file, CALL/RET stack and a VGA write port.
// Optional MUL (opcode 11) is built only when the macro MINI_ALU_MUL_EN is defined.
module mini_alu_core #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int REG_AW      = 3,
  parameter int STACK_DEPTH = 4,
  parameter int COLOR_W     = 3
) (
  input  logic                Clock,
  input  logic                Reset,
  output logic [ADDR_W-1:0]   oIP,
  input  logic [27:0]         iInstruction,
  output logic                oVGAWe,
  output logic [15:0]         oVGAAddr,
  output logic [COLOR_W-1:0]  oVGAColor,
  input  logic                iVGAReady,
  output logic                oStackErr,
  input  logic [REG_AW-1:0]   iDbgSel,
  output logic [DATA_W-1:0]   oDbgData
);
  localparam int NREG  = 2**REG_AW;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [3:0] OP_STO  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_INC  = 4'd4;
  localparam logic [3:0] OP_BLE  = 4'd5;
  localparam logic [3:0] OP_BGE  = 4'd6;
  localparam logic [3:0] OP_JMP  = 4'd7;
  localparam logic [3:0] OP_CALL = 4'd8;
  localparam logic [3:0] OP_RET  = 4'd9;
  localparam logic [3:0] OP_VGA  = 4'd10;
`ifdef MINI_ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd11;
`endif

  logic [ADDR_W-1:0] ip_q, ip_d, iraddr_q, iraddr_d;
  logic [27:0]       ir_q, ir_d;
  logic [DATA_W-1:0] rf_q [NREG];
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q;
  logic              err_q, err_d;

  logic [3:0]        op_s;
  logic [7:0]        d_s, s1_s, s0_s;
  logic [DATA_W-1:0] rs1_s, rs0_s, rf_wdata_s;
  logic              rf_we_s, jmp_s, push_s, pop_s, err_set_s, stall_s;
  logic              sp_full_s, sp_empty_s;
  logic [IDX_W-1:0]  top_idx_s, push_idx_s;

  assign op_s  = ir_q[27:24];
  assign d_s   = ir_q[23:16];
  assign s1_s  = ir_q[15:8];
  assign s0_s  = ir_q[7:0];
  assign rs1_s = rf_q[s1_s[REG_AW-1:0]];
  assign rs0_s = rf_q[s0_s[REG_AW-1:0]];

  assign sp_full_s  = (sp_q == SP_W'(STACK_DEPTH));
  assign sp_empty_s = (sp_q == '0);
  assign top_idx_s  = IDX_W'(sp_q - SP_W'(1));
  assign push_idx_s = IDX_W'(sp_q);

  // Instruction decode: register write, control transfer and stack actions
  always_comb begin
    rf_we_s    = 1'b0;
    rf_wdata_s = '0;
    jmp_s      = 1'b0;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    err_set_s  = 1'b0;
    case (op_s)
      OP_STO:  begin rf_we_s = 1'b1; rf_wdata_s = DATA_W'({s1_s, s0_s}); end
      OP_ADD:  begin rf_we_s = 1'b1; rf_wdata_s = rs1_s + rs0_s; end
      OP_SUB:  begin rf_we_s = 1'b1; rf_wdata_s = rs1_s - rs0_s; end
      OP_INC:  begin rf_we_s = 1'b1; rf_wdata_s = rs1_s + DATA_W'(1); end
      OP_BLE:  jmp_s = (rs1_s <= rs0_s);
      OP_BGE:  jmp_s = (rs1_s >= rs0_s);
      OP_JMP:  jmp_s = 1'b1;
      // A CALL on a full stack loses its return address but still jumps
      OP_CALL: begin jmp_s = 1'b1; push_s = ~sp_full_s; err_set_s = sp_full_s; end
      OP_RET:  begin pop_s = ~sp_empty_s; err_set_s = sp_empty_s; end
`ifdef MINI_ALU_MUL_EN
      OP_MUL:  begin rf_we_s = 1'b1; rf_wdata_s = rs1_s * rs0_s; end
`endif
      default: rf_we_s = 1'b0;
    endcase
  end

  // A VGA request freezes the pipeline until the video RAM takes it
  assign stall_s  = (op_s == OP_VGA) && !iVGAReady;
  assign ip_d     = stall_s ? ip_q :
                    pop_s   ? stack_q[top_idx_s] :
                    jmp_s   ? ADDR_W'(d_s) : ip_q + ADDR_W'(1);
  assign ir_d     = stall_s ? ir_q : ((pop_s || jmp_s) ? 28'h0 : iInstruction);
  assign iraddr_d = stall_s ? iraddr_q : ip_q;
  assign err_d    = err_q | err_set_s;

  // Pipeline, register file, return stack and sticky error flag
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ip_q     <= '0;
      ir_q     <= 28'h0;
      iraddr_q <= '0;
      sp_q     <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      ip_q     <= ip_d;
      ir_q     <= ir_d;
      iraddr_q <= iraddr_d;
      err_q    <= err_d;
      if (rf_we_s) rf_q[d_s[REG_AW-1:0]] <= rf_wdata_s;
      if (push_s) begin
        stack_q[push_idx_s] <= iraddr_q + ADDR_W'(1);
        sp_q                <= sp_q + SP_W'(1);
      end else if (pop_s) begin
        sp_q <= sp_q - SP_W'(1);
      end
    end
  end

  assign oIP       = ip_q;
  assign oVGAWe    = (op_s == OP_VGA);
  assign oVGAAddr  = {rs1_s[7:0], rs0_s[7:0]};
  assign oVGAColor = d_s[COLOR_W-1:0];
  assign oStackErr = err_q;
  assign oDbgData  = rf_q[iDbgSel];
endmodule
